// File: rtl/regwin_pkg.sv
// Shared constants, widths and sequencer state encoding for the register-window
// controller and the windowed register file it drives.
package regwin_pkg;

    localparam int          NWIN      = 4;
    localparam int          MAX_DEPTH = 15;
    localparam logic [15:0] SP_BASE   = 16'h0F00;

    localparam int WIN_W   = 3;
    localparam int RSEL_W  = 2;
    localparam int CWP_W   = 2;
    localparam int DEPTH_W = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SP_SET = 4'd1,
        ST_SP_RD0 = 4'd2,
        ST_SP_WR0 = 4'd3,
        ST_SP_RD1 = 4'd4,
        ST_SP_WR1 = 4'd5,
        ST_FL_RD1 = 4'd6,
        ST_FL_WR1 = 4'd7,
        ST_FL_RD0 = 4'd8,
        ST_FL_WR0 = 4'd9
    } regwin_state_e;

endpackage

// File: rtl/reg_window_ctrl.sv
// Register-window controller: tracks CWP/call depth and spills/fills logical
// registers 2/3 of the clobbered window to a LIFO memory stack on over/underflow.
module reg_window_ctrl #(
    parameter int          NWIN      = regwin_pkg::NWIN,
    parameter int          MAX_DEPTH = regwin_pkg::MAX_DEPTH,
    parameter logic [15:0] SP_BASE   = regwin_pkg::SP_BASE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            call,
    input  logic                            ret,
    output logic                            stall,
    output logic                            err,
    output logic [regwin_pkg::WIN_W-1:0]    window_o,
    output logic                            rf_own,
    output logic [regwin_pkg::RSEL_W-1:0]   rf_rsel,
    input  logic [regwin_pkg::DATA_W-1:0]   rf_rdata,
    output logic                            rf_we,
    output logic [regwin_pkg::RSEL_W-1:0]   rf_wsel,
    output logic [regwin_pkg::DATA_W-1:0]   rf_wdata,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [regwin_pkg::ADDR_W-1:0]   mem_addr,
    output logic [regwin_pkg::DATA_W-1:0]   mem_wdata,
    input  logic [regwin_pkg::DATA_W-1:0]   mem_rdata,
    input  logic                            mem_ack
);
    import regwin_pkg::*;

    localparam logic [CWP_W-1:0]   LP_CWP_LAST    = CWP_W'(NWIN - 1);
    localparam logic [DEPTH_W-1:0] LP_DEPTH_SPILL = DEPTH_W'(NWIN - 1);
    localparam logic [DEPTH_W-1:0] LP_DEPTH_FILL  = DEPTH_W'(NWIN);
    localparam logic [DEPTH_W-1:0] LP_DEPTH_MAX   = DEPTH_W'(MAX_DEPTH);

    regwin_state_e        r_state, w_state_nxt;
    logic [CWP_W-1:0]     r_cwp, w_cwp_nxt, w_cwp_inc, w_cwp_dec;
    logic [DEPTH_W-1:0]   r_depth, w_depth_nxt;
    logic [ADDR_W-1:0]    r_sp, w_sp_nxt;
    logic                 r_err, w_err_nxt;
    logic [DATA_W-1:0]    r_data, w_data_nxt;

    assign w_cwp_inc = (r_cwp == LP_CWP_LAST) ? {CWP_W{1'b0}} : r_cwp + 2'd1;
    assign w_cwp_dec = (r_cwp == {CWP_W{1'b0}}) ? LP_CWP_LAST : r_cwp - 2'd1;
    assign err       = r_err;

    // State and datapath registers; rst aborts any spill/fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cwp   <= {CWP_W{1'b0}};
            r_depth <= {DEPTH_W{1'b0}};
            r_sp    <= SP_BASE;
            r_err   <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cwp   <= w_cwp_nxt;
            r_depth <= w_depth_nxt;
            r_sp    <= w_sp_nxt;
            r_err   <= w_err_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Sequencer: IDLE decodes call/ret, spill/fill states drive RF and memory ports.
    always_comb begin
        w_state_nxt = r_state;
        w_cwp_nxt   = r_cwp;
        w_depth_nxt = r_depth;
        w_sp_nxt    = r_sp;
        w_err_nxt   = r_err;
        w_data_nxt  = r_data;
        window_o    = {1'b0, r_cwp};
        rf_rsel     = 2'd0;
        rf_we       = 1'b0;
        rf_wsel     = 2'd0;
        rf_wdata    = 16'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 16'd0;
        mem_wdata   = 16'd0;
        if (r_state != ST_IDLE) begin
            stall  = 1'b1;
            rf_own = 1'b1;
        end else begin
            stall  = 1'b0;
            rf_own = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (call && ret) begin
                    w_err_nxt = 1'b1;
                end else if (call) begin
                    if (r_depth == LP_DEPTH_MAX) begin
                        w_err_nxt = 1'b1;
                    end else if (r_depth < LP_DEPTH_SPILL) begin
                        w_cwp_nxt   = w_cwp_inc;
                        w_depth_nxt = r_depth + 4'd1;
                    end else begin
                        stall       = 1'b1;
                        w_state_nxt = ST_SP_SET;
                    end
                end else if (ret) begin
                    if (r_depth == {DEPTH_W{1'b0}}) begin
                        w_err_nxt = 1'b1;
                    end else if (r_depth < LP_DEPTH_FILL) begin
                        w_cwp_nxt   = w_cwp_dec;
                        w_depth_nxt = r_depth - 4'd1;
                    end else begin
                        stall       = 1'b1;
                        w_state_nxt = ST_FL_RD1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SP_SET: begin
                window_o    = {1'b0, w_cwp_inc};
                w_state_nxt = ST_SP_RD0;
            end
            ST_SP_RD0: begin
                window_o    = {1'b0, w_cwp_inc};
                rf_rsel     = 2'd2;
                w_state_nxt = ST_SP_WR0;
            end
            // Select is held through the write so rf_rdata stays valid across ack waits.
            ST_SP_WR0: begin
                window_o  = {1'b0, w_cwp_inc};
                rf_rsel   = 2'd2;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_sp;
                mem_wdata = rf_rdata;
                if (mem_ack) begin
                    w_state_nxt = ST_SP_RD1;
                end else begin
                    w_state_nxt = ST_SP_WR0;
                end
            end
            ST_SP_RD1: begin
                window_o    = {1'b0, w_cwp_inc};
                rf_rsel     = 2'd3;
                w_state_nxt = ST_SP_WR1;
            end
            ST_SP_WR1: begin
                window_o  = {1'b0, w_cwp_inc};
                rf_rsel   = 2'd3;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_sp + 16'd1;
                mem_wdata = rf_rdata;
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_sp_nxt    = r_sp + 16'd2;
                    w_cwp_nxt   = w_cwp_inc;
                    w_depth_nxt = r_depth + 4'd1;
                end else begin
                    w_state_nxt = ST_SP_WR1;
                end
            end
            ST_FL_RD1: begin
                mem_req  = 1'b1;
                mem_addr = r_sp - 16'd1;
                if (mem_ack) begin
                    w_data_nxt  = mem_rdata;
                    w_state_nxt = ST_FL_WR1;
                end else begin
                    w_state_nxt = ST_FL_RD1;
                end
            end
            ST_FL_WR1: begin
                rf_we       = 1'b1;
                rf_wsel     = 2'd3;
                rf_wdata    = r_data;
                w_state_nxt = ST_FL_RD0;
            end
            ST_FL_RD0: begin
                mem_req  = 1'b1;
                mem_addr = r_sp - 16'd2;
                if (mem_ack) begin
                    w_data_nxt  = mem_rdata;
                    w_state_nxt = ST_FL_WR0;
                end else begin
                    w_state_nxt = ST_FL_RD0;
                end
            end
            ST_FL_WR0: begin
                rf_we       = 1'b1;
                rf_wsel     = 2'd2;
                rf_wdata    = r_data;
                w_state_nxt = ST_IDLE;
                w_sp_nxt    = r_sp - 16'd2;
                w_cwp_nxt   = w_cwp_dec;
                w_depth_nxt = r_depth - 4'd1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
